cn_timer_sched: RTL
===================

Name: cn_timer_sched

Overview:
- Round-robin scheduler that shares the paint engine's single black-period wait counter (init in, CN out) among up to N requesters (e.g. screen clear, cursor blink, frame flush).
- Each requester raises a level request. The block grants the counter to one requester and fires a one-cycle init to start it.
- It waits for CN, then returns a one-cycle done to the granted requester.
- A watchdog aborts the run and flags an error if CN never arrives.

Parameters:
- N, 3, number of requesters (2..8).
- TIMEOUT, 200000, max cycles spent in WAIT before abort (≥2).
- TW, 18, watchdog counter width; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- req  in  N  per-requester level request, held until its done.
- cn_i  in  1  CN from the shared counter.
- init_o  out  1  one-cycle start pulse to the shared counter's init.
- grant  out  N  one-hot owner of the counter; all-zero when idle.
- done  out  N  one-cycle completion pulse to the owner.
- err  out  1  one-cycle pulse, coincident with done, when the run timed out.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst sampled high at an edge): state=IDLE; init_o, grant, done, err, busy = 0; watchdog=0; cn_q=0; rr pointer=0, so index 0 has highest priority first.
- Reset wins over all other events, including mid-WAIT. The shared counter is not re-inited by this block on reset.
- States: IDLE, START, WAIT, DONE. All outputs are registered.
- IDLE:
  - If any req bit is high at edge k, pick the first set bit scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - After edge k: state=START, grant=onehot(sel), init_o=1, busy=1.
  - If no req bit is high, remain in IDLE.
- START: lasts exactly one cycle. Next state is WAIT, with init_o=0 and watchdog=0.
- WAIT:
  - cn_q registers cn_i every cycle; completion is a rising edge (cn_i=1 and cn_q=0) sampled in WAIT.
  - A CN level still high from a previous run does not complete a new run.
  - On a rising edge: state=DONE, done[sel]=1.
  - Otherwise watchdog increments. When watchdog reaches TIMEOUT-1 with no edge: state=DONE, done[sel]=1, err=1.
  - A rising edge on the same cycle as expiry counts as success, so err=0.
- DONE:
  - Lasts one cycle. Next state is IDLE with grant=0, done=0, err=0, busy=0.
  - ptr is set to (sel+1) mod N.
- Minimum turnaround:
  - Request sampled to init_o takes 1 cycle.
  - A done pulse is followed by at least 1 IDLE cycle before the next init_o.
- req changes while busy:
  - A granted requester that drops req still receives done.
  - Requests arriving while busy wait for IDLE.
- Edges on cn_i outside WAIT are ignored; cn_q still tracks cn_i.
- Outputs are one-hot or zero at all times; done and err never assert outside DONE.
- Watchdog saturation is not needed, because the count stops at TIMEOUT-1.
- The whole block is a single clock domain; cn_i is assumed synchronous to clk.

Test Plan:
- Reset, then only req=3'b001 with cn_i pulsed 10 cycles after init_o. Required:
  - init_o high exactly 1 cycle, 1 cycle after req is sampled; grant=001 throughout.
  - done=001 one cycle after the cn_i rise is sampled; err=0.
  - busy drops the cycle after done.
- req=3'b111 held, each run completed by a cn_i pulse. Required: grant sequence 001, 010, 100, 001, …, with done matching each grant.
- TIMEOUT=16 and cn_i held low. Required: done and err pulse together exactly 16 cycles after entering WAIT, then return to IDLE.
- cn_i held high from before init_o through WAIT. Required: no completion until cn_i falls and rises again; with TIMEOUT=16 and no re-rise, err=1.
- Reset mid-WAIT with req=3'b010 still high. Required:
  - Outputs are all 0 the cycle after rst.
  - After release, the pointer is back at 0: req=3'b110 gives grant=010 first.
- Granted requester drops req one cycle after START. Required: done[sel] still pulses on the cn_i rise; no other requester is granted during the run.

Source files
------------

// File: rtl/cn_timer_sched.sv
// Round-robin arbiter sharing one black-period wait counter (init out, CN in)
// among N requesters, with a watchdog that aborts a run whose CN never arrives.
module cn_timer_sched #(
  parameter int N       = 3,
  parameter int TIMEOUT = 200000,
  parameter int TW      = 18
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         cn_i,
  output logic         init_o,
  output logic [N-1:0] grant,
  output logic [N-1:0] done,
  output logic         err,
  output logic         busy
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] ONE = N'(1);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t        state;
  logic [PW-1:0] ptr, sel, sel_c, cand;
  logic [TW-1:0] wd;
  logic          cn_q, found;
  int            idx;

  // First requester at or after ptr, wrapping round to ptr-1.
  always_comb begin
    sel_c = '0;
    found = 1'b0;
    idx   = 0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      cand = PW'(idx);
      if (!found && req[cand]) begin
        found = 1'b1;
        sel_c = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      sel    <= '0;
      wd     <= '0;
      cn_q   <= 1'b0;
      init_o <= 1'b0;
      grant  <= '0;
      done   <= '0;
      err    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      cn_q <= cn_i;
      case (state)
        IDLE: if (found) begin
          state  <= START;
          sel    <= sel_c;
          grant  <= ONE << sel_c;
          init_o <= 1'b1;
          busy   <= 1'b1;
        end
        START: begin
          state  <= WAIT;
          init_o <= 1'b0;
          wd     <= '0;
        end
        WAIT: begin
          // A rise on the expiry cycle still counts as a clean completion.
          if (cn_i && !cn_q) begin
            state <= DONE;
            done  <= ONE << sel;
          end else if (wd == TW'(TIMEOUT - 1)) begin
            state <= DONE;
            done  <= ONE << sel;
            err   <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          grant <= '0;
          done  <= '0;
          err   <= 1'b0;
          busy  <= 1'b0;
          ptr   <= (sel == PW'(N - 1)) ? '0 : sel + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
